// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher: copies one 32-pixel sprite row from BRAM into a line buffer
// at line start, then emits one 4-bit pixel per clock during active display.
module sprite_line_fetch #(
  parameter int SPR_W   = 32,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               line_start_i,
  input  logic [COORD_W-1:0] line_y_i,
  input  logic               sprite_en_i,
  input  logic [COORD_W-1:0] sprite_x_i,
  input  logic [COORD_W-1:0] sprite_y_i,
  input  logic [COORD_W-1:0] h_count_i,
  output logic               spr_rd_en_o,
  output logic [7:0]         spr_rd_addr_o,
  input  logic [15:0]        spr_rd_data_i,
  output logic               busy_o,
  output logic [3:0]         pixel_o,
  output logic               pixel_valid_o
);

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  localparam logic [COORD_W-1:0] LP_SPR = COORD_W'(SPR_W);

  state_t             r_state, w_state_nxt;
  logic [COORD_W-1:0] w_row, w_col;
  logic               w_hit, w_draw;
  logic [3:0]         r_cnt;
  logic               r_line_hit, r_rd_en, r_busy;
  logic [7:0]         r_addr;
  logic [15:0]        r_linebuf [8];
  logic [15:0]        w_word;
  logic [3:0]         w_nib;
  logic [3:0]         r_pix_p1;
  logic               r_vld_p1;

  assign w_row = line_y_i - sprite_y_i;
  assign w_hit = sprite_en_i && (w_row < LP_SPR);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start_i)
      w_state_nxt = w_hit ? ST_FETCH : ST_IDLE;
    else if (r_state == ST_FETCH && r_cnt == 4'd8)
      w_state_nxt = ST_IDLE;
  end

  // Fetch stage: r_cnt counts edges since the line-start edge; BRAM data for the
  // word addressed at edge k arrives in time for capture at edge k+2.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_cnt      <= '0;
      r_line_hit <= 1'b0;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      for (int i = 0; i < 8; i++) r_linebuf[i] <= '0;
    end else if (line_start_i) begin
      r_line_hit <= w_hit;
      r_cnt      <= '0;
      if (w_hit) begin
        r_rd_en <= 1'b1;
        r_busy  <= 1'b1;
        r_addr  <= {w_row[4:0], 3'd0};
      end else begin
        r_rd_en <= 1'b0;
        r_busy  <= 1'b0;
      end
    end else if (r_state == ST_FETCH) begin
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt <= 4'd6) r_addr  <= r_addr + 8'd1;
      if (r_cnt == 4'd7) r_rd_en <= 1'b0;
      if (r_cnt >= 4'd1) r_linebuf[3'(r_cnt - 4'd1)] <= spr_rd_data_i;
      if (r_cnt == 4'd8) r_busy  <= 1'b0;
    end
  end

  assign w_col  = h_count_i - sprite_x_i;
  assign w_draw = r_line_hit && !r_busy && sprite_en_i && (w_col < LP_SPR);
  assign w_word = r_linebuf[w_col[4:2]];

  always_comb begin
    w_nib = w_word[15:12];
    case (w_col[1:0])
      2'd0: w_nib = w_word[15:12];
      2'd1: w_nib = w_word[11:8];
      2'd2: w_nib = w_word[7:4];
      2'd3: w_nib = w_word[3:0];
      default: w_nib = w_word[15:12];
    endcase
  end

  // Pixel stage: one registered clock from h_count_i to pixel_o; index 0 is transparent.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_pix_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_draw) begin
      r_pix_p1 <= w_nib;
      r_vld_p1 <= (w_nib != 4'd0);
    end else begin
      r_pix_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end
  end

  assign spr_rd_en_o   = r_rd_en;
  assign spr_rd_addr_o = r_addr;
  assign busy_o        = r_busy;
  assign pixel_o       = r_pix_p1;
  assign pixel_valid_o = r_vld_p1;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a registered-read BRAM model.
module tb_sprite_line_fetch;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        line_start_i = 1'b0;
  logic        sprite_en_i = 1'b0;
  logic [9:0]  line_y_i = '0;
  logic [9:0]  sprite_x_i = '0;
  logic [9:0]  sprite_y_i = '0;
  logic [9:0]  h_count_i = '0;
  logic        spr_rd_en_o;
  logic [7:0]  spr_rd_addr_o;
  logic [15:0] spr_rd_data_i = '0;
  logic        busy_o;
  logic [3:0]  pixel_o;
  logic        pixel_valid_o;

  logic [15:0] mem [256];
  int          rd_cycles = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  sprite_line_fetch #(.SPR_W(32), .COORD_W(10)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .line_start_i  (line_start_i),
    .line_y_i      (line_y_i),
    .sprite_en_i   (sprite_en_i),
    .sprite_x_i    (sprite_x_i),
    .sprite_y_i    (sprite_y_i),
    .h_count_i     (h_count_i),
    .spr_rd_en_o   (spr_rd_en_o),
    .spr_rd_addr_o (spr_rd_addr_o),
    .spr_rd_data_i (spr_rd_data_i),
    .busy_o        (busy_o),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spr_rd_en_o) begin
      spr_rd_data_i <= mem[spr_rd_addr_o];
      rd_cycles     <= rd_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse line_start_i and check the full 9-clock fetch sequence from base address.
  task automatic do_fetch(input logic [7:0] base);
    line_start_i = 1'b1;
    step();
    line_start_i = 1'b0;
    chk("E0_rd_en", spr_rd_en_o, 1);
    chk("E0_addr", spr_rd_addr_o, base);
    chk("E0_busy", busy_o, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("Ek_addr", spr_rd_addr_o, base + 8'(k));
      chk("Ek_rd_en", spr_rd_en_o, 1);
      chk("Ek_busy", busy_o, 1);
    end
    step();
    chk("E8_rd_en", spr_rd_en_o, 0);
    chk("E8_busy", busy_o, 1);
    step();
    chk("E9_busy", busy_o, 0);
    chk("E9_rd_en", spr_rd_en_o, 0);
    chk("E9_addr_hold", spr_rd_addr_o, base + 8'd7);
  endtask

  task automatic pix_at(input string tag, input logic [9:0] h, input logic [3:0] ep, input logic ev);
    h_count_i = h;
    step();
    chk({tag, "_pix"}, pixel_o, ep);
    chk({tag, "_vld"}, pixel_valid_o, ev);
  endtask

  task automatic sweep_no_valid(input string tag);
    int vcnt;
    vcnt = 0;
    for (int h = 96; h <= 140; h++) begin
      h_count_i = 10'(h);
      step();
      if (pixel_valid_o) vcnt++;
    end
    chk(tag, vcnt, 0);
  endtask

  initial begin
    int rd0;
    logic [3:0] ep;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h18] = 16'h1230;
    mem[8'h28] = 16'h4000;
    mem[8'h2F] = 16'h0005;
    mem[8'h30] = 16'h7000;
    mem[8'h31] = 16'h000B;

    repeat (3) step();
    chk("rst_rd_en", spr_rd_en_o, 0);
    chk("rst_addr", spr_rd_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_pix", pixel_o, 0);
    chk("rst_vld", pixel_valid_o, 0);
    reset_i = 1'b0;
    step();

    // Row 3 fetch and pixel sweep
    sprite_en_i = 1'b1; sprite_y_i = 10'd10; line_y_i = 10'd13; sprite_x_i = 10'd100;
    rd0 = rd_cycles;
    do_fetch(8'h18);
    chk("rd_cycles_row3", rd_cycles - rd0, 8);
    for (int h = 96; h <= 140; h++) begin
      ep = (h == 100) ? 4'd1 : (h == 101) ? 4'd2 : (h == 102) ? 4'd3 : 4'd0;
      pix_at("sweep_row3", 10'(h), ep, (h >= 100 && h <= 102));
    end

    // Row 32 is outside the sprite
    line_y_i = 10'd42;
    rd0 = rd_cycles;
    line_start_i = 1'b1; step(); line_start_i = 1'b0;
    chk("miss_busy", busy_o, 0);
    repeat (10) step();
    chk("miss_rd_cycles", rd_cycles - rd0, 0);
    sweep_no_valid("miss_sweep_vld");

    // Sprite disabled
    line_y_i = 10'd13; sprite_en_i = 1'b0;
    rd0 = rd_cycles;
    line_start_i = 1'b1; step(); line_start_i = 1'b0;
    repeat (10) step();
    chk("dis_rd_cycles", rd_cycles - rd0, 0);
    chk("dis_busy", busy_o, 0);
    sweep_no_valid("dis_sweep_vld");

    // Y and X wrap: row 6, column 7 from linebuf[1] bits [3:0]
    sprite_en_i = 1'b1; sprite_y_i = 10'd1020; line_y_i = 10'd2; sprite_x_i = 10'd1020;
    do_fetch(8'h30);
    pix_at("wrap_col7", 10'd3, 4'hB, 1'b1);
    pix_at("wrap_col0", 10'd1020, 4'h7, 1'b1);
    pix_at("wrap_left", 10'd1019, 4'h0, 1'b0);
    pix_at("wrap_col32", 10'd28, 4'h0, 1'b0);
    sprite_en_i = 1'b0;
    pix_at("en_drop", 10'd3, 4'h0, 1'b0);
    sprite_en_i = 1'b1;

    // Restart 4 clocks into a fetch: row 3 then row 5
    sprite_y_i = 10'd10; line_y_i = 10'd13; sprite_x_i = 10'd100;
    line_start_i = 1'b1; step(); line_start_i = 1'b0;
    chk("abort_first_addr", spr_rd_addr_o, 8'h18);
    repeat (3) step();
    line_y_i = 10'd15;
    do_fetch(8'h28);
    pix_at("abort_w0", 10'd100, 4'h4, 1'b1);
    pix_at("abort_w0b", 10'd101, 4'h0, 1'b0);
    pix_at("abort_w7", 10'd131, 4'h5, 1'b1);

    // Asynchronous reset in the middle of a fetch
    line_y_i = 10'd13;
    line_start_i = 1'b1; step(); line_start_i = 1'b0;
    repeat (3) step();
    chk("pre_rst_busy", busy_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_rd_en", spr_rd_en_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_vld", pixel_valid_o, 0);
    chk("arst_addr", spr_rd_addr_o, 0);
    step();
    reset_i = 1'b0;
    step();
    pix_at("post_rst_nohit", 10'd100, 4'h0, 1'b0);
    do_fetch(8'h18);
    pix_at("post_rst_pix", 10'd100, 4'h1, 1'b1);
    pix_at("post_rst_pix2", 10'd102, 4'h3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
